store_buffer: RTL

Parametrised store buffer between the MEM stage and data memory. It places store data on the correct byte lanes and generates the byte enables for byte, half, word and (when wide enough) doubleword stores. Accepted stores are queued in a DEPTH-entry FIFO and drained to memory through a valid/ready handshake. The MEM stage continues while memory is busy; it stalls only when the buffer is full.

---
 rtl/store_buffer_pkg.sv | 28 ++
 rtl/store_buffer_lane_align.sv | 38 +++
 rtl/store_buffer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: access size codes, the queued
// entry layout and a size-decoding helper.
package store_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  // Entry fields are sized for the widest supported configuration
  // (ADDR_W <= 64, DATA_W <= 64); narrower builds zero-extend on write
  // and truncate on read.
  localparam int SB_ADDR_MAX_W = 64;
  localparam int SB_DATA_MAX_W = 64;
  localparam int SB_BYTES_MAX  = SB_DATA_MAX_W / 8;

  typedef struct packed {
    logic [SB_ADDR_MAX_W-1:0] addr;
    logic [SB_DATA_MAX_W-1:0] wdata;
    logic [SB_BYTES_MAX-1:0]  byteen;
  } sb_entry_t;

  // Number of bytes touched by an access of the given size code.
  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/store_buffer_lane_align.sv
// Byte-lane placement for stores: turns a right-aligned store into
// lane-positioned write data plus byte enables, and flags accesses that
// are misaligned or wider than the memory word.
module store_lane_align
  import store_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                     size_i,
  input  logic [$clog2(DATA_W/8)-1:0]    ofs_i,
  input  logic [DATA_W-1:0]              data_i,
  output logic [DATA_W/8-1:0]            byteen_o,
  output logic [DATA_W-1:0]              wdata_o,
  output logic                           misalign_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFS_W = $clog2(BYTES);

  logic [3:0]        nb;
  logic [BYTES-1:0]  lane_mask;
  logic [DATA_W-1:0] data_mask;

  // Build the size mask, shift it onto the addressed lanes, check alignment.
  always_comb begin
    nb        = size_bytes(size_i);
    lane_mask = '0;
    data_mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      lane_mask[i]        = (i < int'(nb));
      data_mask[8*i +: 8] = {8{lane_mask[i]}};
    end
    byteen_o   = lane_mask << ofs_i;
    wdata_o    = (data_i & data_mask) << {ofs_i, 3'b000};
    misalign_o = (int'(nb) > BYTES) || ((ofs_i & OFS_W'(nb - 4'd1)) != '0);
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between MEM and data memory. Legal stores are lane-aligned
// and queued in a DEPTH-entry circular FIFO, drained via mem_valid/mem_ready.
// Optional feature macro: STORE_BUFFER_WRITE_COMBINE_EN -- merges a store
// into the youngest entry when both target the same memory word.
// Supported ranges: DATA_W 32 or 64, ADDR_W <= 64, DEPTH power of two >= 2.
module store_buffer
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      st_valid,
  output logic                      st_ready,
  input  logic [1:0]                st_size,
  input  logic [ADDR_W-1:0]         st_addr,
  input  logic [DATA_W-1:0]         st_data,
  output logic                      st_misalign,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [DATA_W/8-1:0]       mem_byteen,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFS_W = $clog2(BYTES);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]     wr_q, wr_d, rd_q, rd_d;
  sb_entry_t          fifo_q [DEPTH];
  sb_entry_t          head, new_entry;
  logic [BYTES-1:0]   ln_byteen;
  logic [DATA_W-1:0]  ln_wdata;
  logic               ln_mis;
  logic [ADDR_W-1:0]  word_addr;
  logic               full, push, pop, merge;

  store_lane_align #(.DATA_W(DATA_W)) u_align (
    .size_i     (st_size),
    .ofs_i      (st_addr[OFS_W-1:0]),
    .data_i     (st_data),
    .byteen_o   (ln_byteen),
    .wdata_o    (ln_wdata),
    .misalign_o (ln_mis)
  );

  assign word_addr = {st_addr[ADDR_W-1:OFS_W], OFS_W'(0)};
  assign new_entry = '{addr:   64'(word_addr),
                       wdata:  64'(ln_wdata),
                       byteen: 8'(ln_byteen)};

  // Pointers differ only in the wrap bit when every slot is occupied.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                 (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign count = wr_q - rd_q;
  assign head  = fifo_q[rd_q[PTR_W-1:0]];

`ifdef STORE_BUFFER_WRITE_COMBINE_EN
  logic [PTR_W-1:0] young_idx;
  sb_entry_t        young, merged;
  logic             addr_match;

  assign young_idx  = wr_q[PTR_W-1:0] - PTR_W'(1);
  assign young      = fifo_q[young_idx];
  assign addr_match = !empty && (ADDR_W'(young.addr) == word_addr);
  // Merging into a head that leaves this cycle would be lost; push instead.
  assign merge      = st_valid && !ln_mis && addr_match &&
                      !((young_idx == rd_q[PTR_W-1:0]) && pop);
  assign st_ready   = !full || addr_match;

  // Overlay the new lanes onto the youngest entry.
  always_comb begin
    merged        = young;
    merged.byteen = young.byteen | 8'(ln_byteen);
    for (int i = 0; i < BYTES; i++) begin
      if (ln_byteen[i]) merged.wdata[8*i +: 8] = ln_wdata[8*i +: 8];
    end
  end
`else
  assign merge    = 1'b0;
  assign st_ready = !full;
`endif

  assign st_misalign = st_valid && ln_mis;
  assign push        = st_valid && st_ready && !ln_mis && !merge;
  assign pop         = !empty && mem_ready;

  // Head entry is presented only while the FIFO holds data.
  assign mem_valid  = !empty;
  assign mem_addr   = empty ? '0 : ADDR_W'(head.addr);
  assign mem_wdata  = empty ? '0 : DATA_W'(head.wdata);
  assign mem_byteen = empty ? '0 : BYTES'(head.byteen);

  // Pointer advance for push and pop; both may happen in one cycle.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) wr_d = wr_q + {{PTR_W{1'b0}}, 1'b1};
    if (pop)  rd_d = rd_q + {{PTR_W{1'b0}}, 1'b1};
  end

  // Pointer registers; reset empties the buffer without draining.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Entry storage: new stores land at the tail, merges update the youngest.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_q[PTR_W-1:0]] <= new_entry;
    end
`ifdef STORE_BUFFER_WRITE_COMBINE_EN
    else if (merge) begin
      fifo_q[young_idx] <= merged;
    end
`endif
  end

endmodule
